mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RAPID RV32I pipeline, sitting directly downstream of the execute stage. It accepts one executed instruction per handshake, either the ALU/branch result (pass-through) or, for load/store instructions, the effective address. It performs the data-memory transaction with byte-lane alignment and load sign/zero extension, then presents the write-back value to the WB stage.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_ex_done  in  1  EX result valid; sampled only when o_ready=1.
- i_control_signal  in  control_s  rapid_pkg control word. Fields used: mem, iop (1=store, 0=load), fcs_opcode[2:0].
- i_rd_output  in  XLEN  effective address when control.mem=1; otherwise the rd result.
- i_store_data  in  XLEN  rs2 value used by stores.
- o_ready  out  1  stage can accept; equals (state==MEM_IDLE).
- o_dmem_req  out  1  data-memory request, held until acknowledged.
- o_dmem_we  out  1  1=write.
- o_dmem_addr  out  XLEN  word address, with bits [1:0] forced to 0.
- o_dmem_wdata  out  XLEN  lane-replicated store data.
- o_dmem_wstrb  out  4  byte enables; 0 for reads.
- i_dmem_ack  in  1  transaction complete; read data valid in the same cycle.
- i_dmem_rdata  in  XLEN  read word.
- o_valid  out  1  write-back result valid.
- o_control_signal  out  control_s  captured control word.
- o_wb_data  out  XLEN  write-back value.
- o_fault  out  1  misaligned or illegal memory access; qualified by o_valid.
- i_wb_ready  in  1  WB consumes the result when o_valid=1.
- o_current_state  out  2  state encoding, for verification only.

## Operation
- States: MEM_IDLE=0, MEM_REQ=1, MEM_RESP=2.
- **MEM_IDLE:** on i_ex_done=1, register the control word, i_rd_output and i_store_data.
  - control.mem=0: o_wb_data=i_rd_output, go to MEM_RESP.
  - Legal and aligned memory access: drive the dmem outputs, go to MEM_REQ.
  - Otherwise: o_fault=1, o_wb_data=0, no request issued, go to MEM_RESP.
- Legal loads use fcs 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores use fcs 000 SB, 001 SH, 010 SW. Any other fcs is illegal.
- Misaligned: half accesses with addr[0]=1; word accesses with addr[1:0]≠0.
- Store lanes:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=addr[1]?1100:0011.
  - SW: wdata=d, wstrb=1111.
- **MEM_REQ:** hold req, we, addr, wdata and wstrb stable until i_dmem_ack=1.
  - On ack, drop o_dmem_req and go to MEM_RESP.
  - Load: o_wb_data = i_dmem_rdata >> (8·addr[1:0]), truncated to 8 or 16 bits, then sign-extended for LB/LH or zero-extended for LBU/LHU. LW passes the full word.
  - Store: o_wb_data=0.
- **MEM_RESP:** o_valid=1. On i_wb_ready=1, clear o_valid and o_fault and go to MEM_IDLE.
- The control word passes through unchanged in every case.

## Timing
- Reset: state MEM_IDLE, o_ready=1, and every registered output is 0: o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_wstrb, o_valid, o_wb_data, o_fault, o_control_signal.
- Reset mid-transaction returns to MEM_IDLE and drops o_dmem_req on that edge. An ack arriving later is ignored.
- Latency, counting the accept edge as cycle 0:
  - Non-memory or fault: o_valid=1 from cycle 1.
  - Memory access: o_dmem_req=1 from cycle 1. An ack at cycle k≥1 gives o_valid=1 at cycle k+1. With a same-cycle ack, the minimum is 2 cycles.
- i_dmem_ack is ignored outside MEM_REQ.
- Input changes after the accept edge are ignored.
- o_ready=0 in MEM_REQ and MEM_RESP. After the WB handshake edge, o_ready=1 on the next cycle, giving one bubble between back-to-back instructions.
- i_ex_done asserted together with i_reset is dropped.

## Test plan
- ADD result 0x0000_1234, mem=0 -> o_valid one cycle after accept, o_wb_data=0x1234, no o_dmem_req.
- LB at addr 0x103, rdata 0x80FF_0000 -> o_dmem_addr 0x100, wstrb 0, o_wb_data 0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH at addr 0x202, data 0xDEAD_BEEF -> wdata 0xBEEF_BEEF, wstrb 1100, we=1. With ack delayed 3 cycles, req stays held and o_valid follows ack by one cycle.
- LW at addr 0x101 -> no request, o_valid with o_fault=1 and o_wb_data 0. Load with fcs 011 -> same fault response.
- i_wb_ready held low for 4 cycles -> o_valid and o_wb_data stable throughout and o_ready=0. The next instruction is accepted only after the handshake.
- i_reset during MEM_REQ -> o_dmem_req=0 on the next edge, state 0, all outputs 0. A stray ack afterwards has no effect.

Source files
------------

// File: rtl/mem_stage_if.sv
// RAPID RV32I shared types and the data-memory bus between the MEM stage
// and the data memory.
package rapid_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [4:0] rd;
        logic       wb_en;
        logic       mem;
        logic       iop;
        logic [2:0] fcs_opcode;
    } control_s;

endpackage

interface mem_stage_if;
    import rapid_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ack, rdata
    );

endinterface

// File: rtl/mem_stage.sv
// RAPID RV32I memory-access stage: byte-lane aligned loads/stores,
// load extension, and pass-through of non-memory results to WB.
module mem_stage
    import rapid_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ex_done,
    input  control_s        i_control_signal,
    input  logic [XLEN-1:0] i_rd_output,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_ready,
    mem_stage_if.master     dmem,
    output logic            o_valid,
    output control_s        o_control_signal,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_fault,
    input  logic            i_wb_ready,
    output logic [1:0]      o_current_state
);

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } state_t;

    state_t          r_state;
    control_s        r_ctrl;
    logic [1:0]      r_off;
    logic            r_req;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_valid;
    logic [XLEN-1:0] r_wb_data;
    logic            r_fault;

    logic [2:0]      w_fcs;
    logic [1:0]      w_lo;
    logic            w_legal;
    logic            w_misal;
    logic [XLEN-1:0] w_st_wdata;
    logic [3:0]      w_st_wstrb;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_ld_data;

    assign w_fcs = i_control_signal.fcs_opcode;
    assign w_lo  = i_rd_output[1:0];

    always_comb begin
        if (i_control_signal.iop)
            w_legal = w_fcs inside {3'b000, 3'b001, 3'b010};
        else
            w_legal = w_fcs inside {3'b000, 3'b001, 3'b010,
                                    3'b100, 3'b101};
    end

    // fcs[1:0] encodes the access size for every legal opcode
    assign w_misal = ((w_fcs[1:0] == 2'b01) && w_lo[0])
                   || ((w_fcs[1:0] == 2'b10) && (w_lo != 2'b00));

    always_comb begin
        w_st_wdata = i_store_data;
        w_st_wstrb = 4'b1111;
        case (w_fcs[1:0])
            2'b00: begin
                w_st_wdata = {4{i_store_data[7:0]}};
                w_st_wstrb = 4'b0001 << w_lo;
            end
            2'b01: begin
                w_st_wdata = {2{i_store_data[15:0]}};
                w_st_wstrb = w_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_wdata = i_store_data;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    assign w_shifted = dmem.rdata >> {r_off, 3'b000};

    always_comb begin
        w_ld_data = '0;
        case (r_ctrl.fcs_opcode)
            3'b000:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_ld_data = dmem.rdata;
            3'b100:  w_ld_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_ld_data = {16'd0, w_shifted[15:0]};
            default: w_ld_data = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= MEM_IDLE;
            r_ctrl    <= '0;
            r_off     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_valid   <= 1'b0;
            r_wb_data <= '0;
            r_fault   <= 1'b0;
        end else begin
            unique case (r_state)
                MEM_IDLE: begin
                    if (i_ex_done) begin
                        r_ctrl <= i_control_signal;
                        r_off  <= w_lo;
                        if (!i_control_signal.mem) begin
                            r_wb_data <= i_rd_output;
                            r_fault   <= 1'b0;
                            r_valid   <= 1'b1;
                            r_state   <= MEM_RESP;
                        end else if (w_legal && !w_misal) begin
                            r_req   <= 1'b1;
                            r_we    <= i_control_signal.iop;
                            r_addr  <= {i_rd_output[XLEN-1:2], 2'b00};
                            r_wdata <= i_control_signal.iop ? w_st_wdata : '0;
                            r_wstrb <= i_control_signal.iop ? w_st_wstrb : 4'b0000;
                            r_fault <= 1'b0;
                            r_state <= MEM_REQ;
                        end else begin
                            r_fault   <= 1'b1;
                            r_wb_data <= '0;
                            r_valid   <= 1'b1;
                            r_state   <= MEM_RESP;
                        end
                    end
                end
                MEM_REQ: begin
                    if (dmem.ack) begin
                        r_req     <= 1'b0;
                        r_valid   <= 1'b1;
                        r_wb_data <= r_ctrl.iop ? '0 : w_ld_data;
                        r_state   <= MEM_RESP;
                    end
                end
                MEM_RESP: begin
                    if (i_wb_ready) begin
                        r_valid <= 1'b0;
                        r_fault <= 1'b0;
                        r_state <= MEM_IDLE;
                    end
                end
                default: r_state <= MEM_IDLE;
            endcase
        end
    end

    assign o_ready          = (r_state == MEM_IDLE);
    assign o_current_state  = r_state;
    assign o_valid          = r_valid;
    assign o_control_signal = r_ctrl;
    assign o_wb_data        = r_wb_data;
    assign o_fault          = r_fault;
    assign dmem.req         = r_req;
    assign dmem.we          = r_we;
    assign dmem.addr        = r_addr;
    assign dmem.wdata       = r_wdata;
    assign dmem.wstrb       = r_wstrb;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads, stores, faults,
// WB back-pressure and mid-transaction reset.
module tb_mem_stage;
    import rapid_pkg::*;

    typedef struct {
        logic [31:0] wb;
        logic        fault;
        control_s    ctrl;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          delay;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_done;
    control_s    ctrl_in;
    logic [31:0] rd_out;
    logic [31:0] st_data;
    logic        ready;
    logic        valid;
    control_s    ctrl_out;
    logic [31:0] wb_data;
    logic        fault;
    logic        wb_ready;
    logic [1:0]  state;

    mem_stage_if dmem_if ();

    mem_stage u_dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_ex_done        (ex_done),
        .i_control_signal (ctrl_in),
        .i_rd_output      (rd_out),
        .i_store_data     (st_data),
        .o_ready          (ready),
        .dmem             (dmem_if),
        .o_valid          (valid),
        .o_control_signal (ctrl_out),
        .o_wb_data        (wb_data),
        .o_fault          (fault),
        .i_wb_ready       (wb_ready),
        .o_current_state  (state)
    );

    always #5 clk = ~clk;

    wb_exp_t  wb_q[$];
    mem_exp_t mem_q[$];
    int       n_checks = 0;
    int       n_err = 0;
    logic     mem_auto = 1'b1;
    logic     stray_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic control_s mk(input logic mem, input logic iop,
                                    input logic [2:0] fcs,
                                    input logic [4:0] rd);
        control_s c;
        c.rd = rd;
        c.wb_en = ~(mem & iop);
        c.mem = mem;
        c.iop = iop;
        c.fcs_opcode = fcs;
        return c;
    endfunction

    task automatic push_wb(input logic [31:0] wb, input logic f,
                           input control_s c);
        wb_exp_t e;
        e.wb = wb;
        e.fault = f;
        e.ctrl = c;
        wb_q.push_back(e);
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input logic [3:0] ws,
                            input logic [31:0] rdat, input int dly);
        mem_exp_t e;
        e.addr = a;
        e.we = we;
        e.wdata = wd;
        e.wstrb = ws;
        e.rdata = rdat;
        e.delay = dly;
        mem_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input control_s c, input logic [31:0] rd,
                         input logic [31:0] sd);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", {31'd0, ready}, 32'd1);
        ctrl_in = c;
        rd_out = rd;
        st_data = sd;
        ex_done = 1'b1;
        @(negedge clk);
        ex_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("return_to_idle", {31'd0, ready}, 32'd1);
    endtask

    // WB monitor: one pop per handshake
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (valid && wb_ready) begin
                if (wb_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL wb_unexpected: got %h expected none",
                             wb_data);
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    chk("wb_data", wb_data, e.wb);
                    chk("wb_fault", {31'd0, fault}, {31'd0, e.fault});
                    chk("wb_ctrl", {21'd0, ctrl_out}, {21'd0, e.ctrl});
                end
            end
        end
    end

    // Data-memory responder; checks every cycle the request is held
    initial begin
        mem_exp_t cur;
        logic     busy = 1'b0;
        int       cnt = 0;
        dmem_if.ack = 1'b0;
        dmem_if.rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!mem_auto) begin
                dmem_if.ack = stray_ack;
                dmem_if.rdata = 32'hFFFF_FFFF;
            end else if (dmem_if.ack) begin
                dmem_if.ack = 1'b0;
                chk("valid_after_ack", {31'd0, valid}, 32'd1);
                chk("req_drop", {31'd0, dmem_if.req}, 32'd0);
            end else if (dmem_if.req) begin
                if (!busy && mem_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL dmem_unexpected: got req addr %h expected none",
                             dmem_if.addr);
                end else begin
                    if (!busy) begin
                        cur = mem_q.pop_front();
                        cnt = cur.delay;
                        busy = 1'b1;
                    end
                    chk("dmem_addr", dmem_if.addr, cur.addr);
                    chk("dmem_we", {31'd0, dmem_if.we}, {31'd0, cur.we});
                    chk("dmem_wstrb", {28'd0, dmem_if.wstrb}, {28'd0, cur.wstrb});
                    if (cur.we)
                        chk("dmem_wdata", dmem_if.wdata, cur.wdata);
                    if (cnt == 0) begin
                        dmem_if.ack = 1'b1;
                        dmem_if.rdata = cur.rdata;
                        busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        control_s c;
        rst = 1'b1;
        ex_done = 1'b0;
        ctrl_in = '0;
        rd_out = '0;
        st_data = '0;
        wb_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_req", {31'd0, dmem_if.req}, 32'd0);
        chk("rst_we", {31'd0, dmem_if.we}, 32'd0);
        chk("rst_addr", dmem_if.addr, 32'd0);
        chk("rst_wdata", dmem_if.wdata, 32'd0);
        chk("rst_wstrb", {28'd0, dmem_if.wstrb}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_wb", wb_data, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_ctrl", {21'd0, ctrl_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        c = mk(1'b0, 1'b0, 3'b000, 5'd3);
        push_wb(32'h0000_1234, 1'b0, c);
        issue(c, 32'h0000_1234, 32'h0);
        chk("add_valid_c1", {31'd0, valid}, 32'd1);
        chk("add_no_req", {31'd0, dmem_if.req}, 32'd0);
        wait_idle();

        c = mk(1'b1, 1'b0, 3'b000, 5'd5);
        push_mem(32'h100, 1'b0, 32'h0, 4'b0000, 32'h80FF_0000, 0);
        push_wb(32'hFFFF_FF80, 1'b0, c);
        issue(c, 32'h103, 32'h0);
        chk("lb_req_c1", {31'd0, dmem_if.req}, 32'd1);
        wait_idle();

        c = mk(1'b1, 1'b0, 3'b100, 5'd6);
        push_mem(32'h100, 1'b0, 32'h0, 4'b0000, 32'h80FF_0000, 0);
        push_wb(32'h0000_0080, 1'b0, c);
        issue(c, 32'h103, 32'h0);
        wait_idle();

        c = mk(1'b1, 1'b1, 3'b001, 5'd0);
        push_mem(32'h200, 1'b1, 32'hBEEF_BEEF, 4'b1100, 32'h0, 3);
        push_wb(32'h0, 1'b0, c);
        issue(c, 32'h202, 32'hDEAD_BEEF);
        wait_idle();

        c = mk(1'b1, 1'b1, 3'b000, 5'd0);
        push_mem(32'h100, 1'b1, 32'h7878_7878, 4'b0010, 32'h0, 1);
        push_wb(32'h0, 1'b0, c);
        issue(c, 32'h101, 32'h1234_5678);
        wait_idle();

        c = mk(1'b1, 1'b1, 3'b010, 5'd0);
        push_mem(32'h300, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0, 0);
        push_wb(32'h0, 1'b0, c);
        issue(c, 32'h300, 32'hCAFE_F00D);
        wait_idle();

        c = mk(1'b1, 1'b0, 3'b001, 5'd7);
        push_mem(32'h100, 1'b0, 32'h0, 4'b0000, 32'h8001_5555, 2);
        push_wb(32'hFFFF_8001, 1'b0, c);
        issue(c, 32'h102, 32'h0);
        wait_idle();

        c = mk(1'b1, 1'b0, 3'b101, 5'd8);
        push_mem(32'h100, 1'b0, 32'h0, 4'b0000, 32'h1234_9ABC, 0);
        push_wb(32'h0000_9ABC, 1'b0, c);
        issue(c, 32'h100, 32'h0);
        wait_idle();

        c = mk(1'b1, 1'b0, 3'b010, 5'd9);
        push_mem(32'h104, 1'b0, 32'h0, 4'b0000, 32'h1122_3344, 0);
        push_wb(32'h1122_3344, 1'b0, c);
        issue(c, 32'h104, 32'h0);
        wait_idle();

        c = mk(1'b1, 1'b0, 3'b010, 5'd10);
        push_wb(32'h0, 1'b1, c);
        issue(c, 32'h101, 32'h0);
        chk("lw_mis_valid_c1", {31'd0, valid}, 32'd1);
        chk("lw_mis_no_req", {31'd0, dmem_if.req}, 32'd0);
        wait_idle();

        c = mk(1'b1, 1'b0, 3'b011, 5'd11);
        push_wb(32'h0, 1'b1, c);
        issue(c, 32'h100, 32'h0);
        wait_idle();

        c = mk(1'b1, 1'b1, 3'b001, 5'd0);
        push_wb(32'h0, 1'b1, c);
        issue(c, 32'h201, 32'h5A5A_5A5A);
        wait_idle();

        c = mk(1'b1, 1'b1, 3'b100, 5'd0);
        push_wb(32'h0, 1'b1, c);
        issue(c, 32'h200, 32'h5A5A_5A5A);
        wait_idle();

        wb_ready = 1'b0;
        c = mk(1'b0, 1'b0, 3'b000, 5'd12);
        push_wb(32'h0000_ABCD, 1'b0, c);
        push_wb(32'h0000_5555, 1'b0, mk(1'b0, 1'b0, 3'b000, 5'd13));
        issue(c, 32'h0000_ABCD, 32'h0);
        ctrl_in = mk(1'b0, 1'b0, 3'b000, 5'd13);
        rd_out = 32'h0000_5555;
        ex_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {31'd0, valid}, 32'd1);
            chk("stall_wb", wb_data, 32'h0000_ABCD);
            chk("stall_ready", {31'd0, ready}, 32'd0);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_hs", {31'd0, ready}, 32'd1);
        @(negedge clk);
        ex_done = 1'b0;
        chk("next_accepted", wb_data, 32'h0000_5555);
        wait_idle();

        mem_auto = 1'b0;
        issue(mk(1'b1, 1'b0, 3'b010, 5'd14), 32'h400, 32'h0);
        chk("rq_req_c1", {31'd0, dmem_if.req}, 32'd1);
        chk("rq_state", {30'd0, state}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_req", {31'd0, dmem_if.req}, 32'd0);
        chk("mrst_state", {30'd0, state}, 32'd0);
        chk("mrst_valid", {31'd0, valid}, 32'd0);
        chk("mrst_wstrb", {28'd0, dmem_if.wstrb}, 32'd0);
        chk("mrst_addr", dmem_if.addr, 32'd0);
        chk("mrst_ctrl", {21'd0, ctrl_out}, 32'd0);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        chk("stray_state", {30'd0, state}, 32'd0);
        chk("stray_valid", {31'd0, valid}, 32'd0);
        chk("stray_wb", wb_data, 32'd0);
        @(negedge clk);
        mem_auto = 1'b1;

        rst = 1'b1;
        ctrl_in = mk(1'b0, 1'b0, 3'b000, 5'd15);
        rd_out = 32'h77;
        ex_done = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ex_done = 1'b0;
        @(negedge clk);
        chk("exrst_state", {30'd0, state}, 32'd0);
        chk("exrst_valid", {31'd0, valid}, 32'd0);

        c = mk(1'b0, 1'b0, 3'b000, 5'd16);
        push_wb(32'h0000_0009, 1'b0, c);
        issue(c, 32'h9, 32'h0);
        wait_idle();
        repeat (3) @(negedge clk);

        chk("wb_q_empty", wb_q.size(), 32'd0);
        chk("mem_q_empty", mem_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
